// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Function : VGA raster timing generator (640x480@60 at defaults) with
//            latency-matched sync/blank and frame/line strobes.
// Revision : 1.0
// ============================================================================
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned DRAW_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        oHS_N,
  output logic        oVS_N,
  output logic        oBLANK_N,
  output logic        startOfFrame,
  output logic        lineEnd
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] c_H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] c_V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] c_H_ACTIVE = 11'(H_ACTIVE);
  localparam logic [10:0] c_V_ACTIVE = 11'(V_ACTIVE);
  localparam logic [10:0] c_HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        sof_q, sof_d;
  logic        line_end_q, line_end_d;
  logic        hs_raw_n, vs_raw_n, blank_raw_n;

  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == c_H_LAST) begin
      x_d = 11'd0;
      y_d = (y_q == c_V_LAST) ? 11'd0 : y_q + 11'd1;
    end
    // Strobes look at the next count so they line up with the counter registers.
    sof_d      = (x_d == 11'd0) && (y_d == 11'd0);
    line_end_d = (x_d == c_H_LAST);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x_q        <= 11'd0;
      y_q        <= 11'd0;
      sof_q      <= 1'b0;
      line_end_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      sof_q      <= sof_d;
      line_end_q <= line_end_d;
    end
  end

  always_comb begin
    hs_raw_n    = !((x_q >= c_HS_START) && (x_q < c_HS_END));
    vs_raw_n    = !((y_q >= c_VS_START) && (y_q < c_VS_END));
    blank_raw_n = (x_q < c_H_ACTIVE) && (y_q < c_V_ACTIVE);
  end

  generate
    if (DRAW_LATENCY == 0) begin : g_no_delay
      // Hold outputs inactive until the first edge after reset release.
      logic run_q, run_d;

      always_comb begin
        run_d = 1'b1;
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) run_q <= 1'b0;
        else         run_q <= run_d;
      end

      assign oHS_N    = hs_raw_n | ~run_q;
      assign oVS_N    = vs_raw_n | ~run_q;
      assign oBLANK_N = blank_raw_n & run_q;
    end else begin : g_delay
      // Each stage is {hs_n, vs_n, blank_n}; inactive pattern is 3'b110.
      logic [DRAW_LATENCY-1:0][2:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = {hs_raw_n, vs_raw_n, blank_raw_n};
        for (int i = 1; i < int'(DRAW_LATENCY); i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) pipe_q <= {DRAW_LATENCY{3'b110}};
        else         pipe_q <= pipe_d;
      end

      assign oHS_N    = pipe_q[DRAW_LATENCY-1][2];
      assign oVS_N    = pipe_q[DRAW_LATENCY-1][1];
      assign oBLANK_N = pipe_q[DRAW_LATENCY-1][0];
    end
  endgenerate

  assign pixelX       = x_q;
  assign pixelY       = y_q;
  assign startOfFrame = sof_q;
  assign lineEnd      = line_end_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Function : Randomized reset/run bench for vga_sync_gen at three latencies
//            against a time-indexed raster model.
// Revision : 1.0
// ============================================================================
module tb_vga_sync_gen;

  localparam int H_ACTIVE = 16, H_FP = 4, H_SYNC = 6, H_BP = 4;
  localparam int V_ACTIVE = 10, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;
  localparam int NDUT  = 3;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   t     = 0;
  int   lat [NDUT] = '{0, 1, 3};

  logic [10:0] px [NDUT];
  logic [10:0] py [NDUT];
  logic        hs [NDUT];
  logic        vs [NDUT];
  logic        bl [NDUT];
  logic        sof[NDUT];
  logic        le [NDUT];

  always #5 clk = ~clk;

  vga_sync_gen #(.H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
                 .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
                 .DRAW_LATENCY(0)) u_dut0 (
    .clk(clk), .resetN(resetN), .pixelX(px[0]), .pixelY(py[0]), .oHS_N(hs[0]),
    .oVS_N(vs[0]), .oBLANK_N(bl[0]), .startOfFrame(sof[0]), .lineEnd(le[0]));

  vga_sync_gen #(.H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
                 .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
                 .DRAW_LATENCY(1)) u_dut1 (
    .clk(clk), .resetN(resetN), .pixelX(px[1]), .pixelY(py[1]), .oHS_N(hs[1]),
    .oVS_N(vs[1]), .oBLANK_N(bl[1]), .startOfFrame(sof[1]), .lineEnd(le[1]));

  vga_sync_gen #(.H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
                 .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
                 .DRAW_LATENCY(3)) u_dut3 (
    .clk(clk), .resetN(resetN), .pixelX(px[2]), .pixelY(py[2]), .oHS_N(hs[2]),
    .oVS_N(vs[2]), .oBLANK_N(bl[2]), .startOfFrame(sof[2]), .lineEnd(le[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  // Expected outputs as a function of edges elapsed since reset release.
  task automatic check_all(input bit in_reset);
    int x, y, td, xd, yd;
    logic ehs, evs, ebl, esof, ele;
    for (int i = 0; i < NDUT; i++) begin
      if (in_reset) begin
        x = 0; y = 0; ehs = 1'b1; evs = 1'b1; ebl = 1'b0; esof = 1'b0; ele = 1'b0;
      end else begin
        if (lat[i] == 0 && t == 0) continue;
        x    = t % HT;
        y    = (t / HT) % VT;
        esof = (t > 0) && (t % FRAME == 0);
        ele  = (x == HT - 1);
        td   = t - lat[i];
        if (td < 0) begin
          ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
        end else begin
          xd  = td % HT;
          yd  = (td / HT) % VT;
          ehs = !(xd >= H_ACTIVE + H_FP && xd < H_ACTIVE + H_FP + H_SYNC);
          evs = !(yd >= V_ACTIVE + V_FP && yd < V_ACTIVE + V_FP + V_SYNC);
          ebl = (xd < H_ACTIVE) && (yd < V_ACTIVE);
        end
      end
      chk($sformatf("L%0d_pixelX", lat[i]),   32'(px[i]), 32'(x));
      chk($sformatf("L%0d_pixelY", lat[i]),   32'(py[i]), 32'(y));
      chk($sformatf("L%0d_hs_n", lat[i]),     32'(hs[i]), 32'(ehs));
      chk($sformatf("L%0d_vs_n", lat[i]),     32'(vs[i]), 32'(evs));
      chk($sformatf("L%0d_blank_n", lat[i]),  32'(bl[i]), 32'(ebl));
      chk($sformatf("L%0d_sof", lat[i]),      32'(sof[i]), 32'(esof));
      chk($sformatf("L%0d_lineEnd", lat[i]),  32'(le[i]), 32'(ele));
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      t++;
      check_all(1'b0);
    end
  endtask

  // Called 1 time unit after an edge (or at time 0); asserts reset mid-cycle.
  task automatic do_reset(input int hold);
    #2;
    resetN = 1'b0;
    #1;
    check_all(1'b1);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check_all(1'b1);
    end
    #3;
    resetN = 1'b1;
    t = 0;
    #1;
    check_all(1'b0);
  endtask

  initial begin
    do_reset(2);
    run_cycles(2 * FRAME + 37);

    // Mid-frame reset inside the HS window (x=23, y=8).
    do_reset($urandom_range(1, 4));
    run_cycles(8 * HT + 23);
    do_reset($urandom_range(1, 4));
    run_cycles(FRAME + 40);

    for (int ep = 0; ep < 8; ep++) begin
      do_reset($urandom_range(1, 4));
      run_cycles($urandom_range(40, 3 * FRAME));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
